// File: rtl/seg_pkg.sv
// Shared types and digit-walk helpers for the seven-segment scan controller.
// Helpers give the first / next enabled digit of a 4-bit scan mask.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } scan_state_t;

  // Next set bit strictly above idx, wrapping; idx itself if it is the only one.
  function automatic logic [1:0] next_digit(
    input logic [1:0] idx,
    input logic [NUM_DIGITS-1:0] mask
  );
    logic [1:0] n;
    logic [1:0] j;
    logic found;
    n = idx;
    found = 1'b0;
    for (int k = 1; k <= NUM_DIGITS; k++) begin
      j = idx + 2'(k);
      if (!found && mask[j]) begin
        n = j;
        found = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic logic [1:0] first_digit(
    input logic [NUM_DIGITS-1:0] mask
  );
    return next_digit(2'd3, mask);
  endfunction

  function automatic logic [NUM_DIGITS-1:0] onehot(
    input logic [1:0] idx
  );
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Loadable down-counter timing one BLANK or SHOW slot.
// done is high on the final cycle of a slot loaded with length-1.
module seg_slot_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexed scan sequencer for a 4-digit seven-segment display.
// Each digit gets a blanking dead-time, then its lit slot.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [NUM_DIGITS-1:0] digit_en,
  output logic [NUM_DIGITS-1:0] select,
  output logic                  mux_enable,
  output logic [NUM_DIGITS-1:0] anode_n,
  output logic                  frame_tick
);

  localparam int MAXC = (PRESCALE > BLANK_CYCLES) ?
                        PRESCALE : BLANK_CYCLES;
  localparam int W = $clog2(MAXC + 1);
  localparam logic [W-1:0] SHOW_LD  = W'(PRESCALE - 1);
  localparam logic [W-1:0] BLANK_LD = W'(BLANK_CYCLES - 1);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("PRESCALE must be >= 1");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("BLANK_CYCLES must be >= 1");
  end

  scan_state_t state;
  logic [1:0]  idx;
  logic [1:0]  nidx;
  logic [1:0]  fidx;
  logic        has_mask;
  logic        load;
  logic        clear;
  logic [W-1:0] load_val;
  logic        done;

  seg_slot_timer #(
    .W(W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .clear   (clear),
    .load_val(load_val),
    .done    (done)
  );

  always_comb begin
    has_mask = |digit_en;
    nidx     = next_digit(idx, digit_en);
    fidx     = first_digit(digit_en);
    load     = 1'b0;
    clear    = 1'b0;
    load_val = BLANK_LD;
    case (state)
      IDLE: load = enable && has_mask;
      BLANK: begin
        clear    = !enable;
        load     = enable && done;
        load_val = SHOW_LD;
      end
      SHOW: begin
        clear = !enable || (done && !has_mask);
        load  = enable && done && has_mask;
      end
      default: clear = 1'b1;
    endcase
  end

  // enable low wins over any slot-end transition in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 2'd0;
      select     <= 4'b0001;
      mux_enable <= 1'b0;
      anode_n    <= 4'b1111;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && has_mask) begin
            state      <= BLANK;
            idx        <= fidx;
            select     <= onehot(fidx);
            mux_enable <= 1'b1;
          end
        end
        BLANK: begin
          if (!enable) begin
            state      <= IDLE;
            mux_enable <= 1'b0;
          end else if (done) begin
            state   <= SHOW;
            anode_n <= ~select;
          end
        end
        SHOW: begin
          if (!enable || (done && !has_mask)) begin
            state      <= IDLE;
            mux_enable <= 1'b0;
            anode_n    <= 4'b1111;
          end else if (done) begin
            state      <= BLANK;
            idx        <= nidx;
            select     <= onehot(nidx);
            anode_n    <= 4'b1111;
            frame_tick <= (nidx <= idx);
          end
        end
        default: begin
          state      <= IDLE;
          mux_enable <= 1'b0;
          anode_n    <= 4'b1111;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with PRESCALE=4, BLANK_CYCLES=1.
// Table of per-cycle vectors plus hand sequences for drop/mask/reset cases.
module tb_seg_scan_controller;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [3:0] digit_en;
  logic [3:0] select;
  logic       mux_enable;
  logic [3:0] anode_n;
  logic       frame_tick;

  int total;
  int bad;

  typedef struct {
    logic       en;
    logic [3:0] mask;
    logic [3:0] sel;
    logic       mux;
    logic [3:0] an;
    logic       ft;
  } vec_t;

  vec_t vt[$];

  seg_scan_controller #(
    .PRESCALE    (4),
    .BLANK_CYCLES(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .digit_en  (digit_en),
    .select    (select),
    .mux_enable(mux_enable),
    .anode_n   (anode_n),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string      nm,
    input logic [3:0] s,
    input logic       m,
    input logic [3:0] a,
    input logic       f
  );
    total++;
    if (select !== s || mux_enable !== m ||
        anode_n !== a || frame_tick !== f) begin
      bad++;
      $display("FAIL %s: got sel=%b mux=%b an=%b ft=%b want sel=%b mux=%b an=%b ft=%b",
               nm, select, mux_enable, anode_n, frame_tick, s, m, a, f);
    end
  endtask

  // One slot: a BLANK cycle then four SHOW cycles.
  task automatic slot(
    input logic [3:0] bm,
    input logic [3:0] sm,
    input logic [3:0] s,
    input logic       f
  );
    vec_t v;
    v.en = 1'b1; v.mask = bm; v.sel = s;
    v.mux = 1'b1; v.an = 4'b1111; v.ft = f;
    vt.push_back(v);
    for (int k = 0; k < 4; k++) begin
      v.en = 1'b1; v.mask = sm; v.sel = s;
      v.mux = 1'b1; v.an = ~s; v.ft = 1'b0;
      vt.push_back(v);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    enable = 1'b0;
    digit_en = 4'b0000;

    slot(4'b1111, 4'b1111, 4'b0001, 1'b0);
    slot(4'b1111, 4'b1111, 4'b0010, 1'b0);
    slot(4'b1111, 4'b1111, 4'b0100, 1'b0);
    slot(4'b1111, 4'b1111, 4'b1000, 1'b0);
    slot(4'b1111, 4'b1111, 4'b0001, 1'b1);
    slot(4'b1010, 4'b1010, 4'b0010, 1'b0);
    slot(4'b1010, 4'b1010, 4'b1000, 1'b0);
    slot(4'b1010, 4'b1010, 4'b0010, 1'b1);
    slot(4'b1010, 4'b0100, 4'b1000, 1'b0);
    slot(4'b0100, 4'b0100, 4'b0100, 1'b1);
    slot(4'b0100, 4'b0100, 4'b0100, 1'b1);
    slot(4'b0100, 4'b0100, 4'b0100, 1'b1);

    #12;
    chk("reset", 4'b0001, 1'b0, 4'b1111, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("idle_off", 4'b0001, 1'b0, 4'b1111, 1'b0);

    for (int i = 0; i < vt.size(); i++) begin
      enable = vt[i].en;
      digit_en = vt[i].mask;
      tick();
      chk($sformatf("vec%0d", i), vt[i].sel, vt[i].mux,
          vt[i].an, vt[i].ft);
    end

    enable = 1'b0;
    tick();
    chk("drop_idle", 4'b0100, 1'b0, 4'b1111, 1'b0);
    enable = 1'b1;
    digit_en = 4'b1111;
    tick();
    chk("restart_blank", 4'b0001, 1'b1, 4'b1111, 1'b0);
    repeat (4) begin
      tick();
      chk("restart_show0", 4'b0001, 1'b1, 4'b1110, 1'b0);
    end
    tick();
    chk("blank1", 4'b0010, 1'b1, 4'b1111, 1'b0);
    tick();
    chk("show1_c1", 4'b0010, 1'b1, 4'b1101, 1'b0);
    tick();
    chk("show1_c2", 4'b0010, 1'b1, 4'b1101, 1'b0);
    enable = 1'b0;
    tick();
    chk("drop_show", 4'b0010, 1'b0, 4'b1111, 1'b0);
    enable = 1'b1;
    tick();
    chk("reen_blank", 4'b0001, 1'b1, 4'b1111, 1'b0);

    enable = 1'b0;
    tick();
    enable = 1'b1;
    digit_en = 4'b0000;
    repeat (3) begin
      tick();
      chk("zero_mask", 4'b0001, 1'b0, 4'b1111, 1'b0);
    end

    digit_en = 4'b1111;
    tick();
    chk("m_blank0", 4'b0001, 1'b1, 4'b1111, 1'b0);
    repeat (4) begin
      tick();
      chk("m_show0", 4'b0001, 1'b1, 4'b1110, 1'b0);
    end
    tick();
    chk("m_blank1", 4'b0010, 1'b1, 4'b1111, 1'b0);
    tick();
    chk("m_show1", 4'b0010, 1'b1, 4'b1101, 1'b0);
    digit_en = 4'b0001;
    repeat (3) begin
      tick();
      chk("m_show1_hold", 4'b0010, 1'b1, 4'b1101, 1'b0);
    end
    tick();
    chk("m_wrap", 4'b0001, 1'b1, 4'b1111, 1'b1);
    tick();
    chk("z_show0", 4'b0001, 1'b1, 4'b1110, 1'b0);
    digit_en = 4'b0000;
    repeat (3) begin
      tick();
      chk("z_show0_hold", 4'b0001, 1'b1, 4'b1110, 1'b0);
    end
    tick();
    chk("z_idle", 4'b0001, 1'b0, 4'b1111, 1'b0);
    tick();
    chk("z_idle2", 4'b0001, 1'b0, 4'b1111, 1'b0);

    digit_en = 4'b1111;
    tick();
    repeat (4) tick();
    tick();
    repeat (4) tick();
    tick();
    chk("r_blank2", 4'b0100, 1'b1, 4'b1111, 1'b0);
    tick();
    tick();
    chk("r_show2", 4'b0100, 1'b1, 4'b1011, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_async", 4'b0001, 1'b0, 4'b1111, 1'b0);
    tick();
    chk("r_held", 4'b0001, 1'b0, 4'b1111, 1'b0);
    enable = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("r_post", 4'b0001, 1'b0, 4'b1111, 1'b0);
    enable = 1'b1;
    tick();
    chk("r_start", 4'b0001, 1'b1, 4'b1111, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
